// File: rtl/fcn_tiled_if.sv
// fcn_tiled_if: handshake and parameter-bus bundle for fcn_tiled.
//   master modport : driven by the upstream feature extractor / host
//   slave  modport : used by fcn_tiled
// Signals:
//   in_valid/in_ready/in_data      input byte stream (index order)
//   wr_en/wr_sel/wr_addr/wr_data   weight/bias write port, wr_err reject pulse
//   cfg_shift                      requantisation right shift
//   out_valid/out_ready/out_logit  result handshake
//   busy                           engine not idle
interface fcn_tiled_if #(
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 11
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DW-1:0]     in_data;
    logic                     wr_en;
    logic [1:0]               wr_sel;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DW-1:0]     wr_data;
    logic                     wr_err;
    logic [4:0]               cfg_shift;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_logit;
    logic                     busy;

    modport master (
        output in_valid, in_data, wr_en, wr_sel, wr_addr, wr_data, cfg_shift, out_ready,
        input  in_ready, wr_err, out_valid, out_logit, busy
    );

    modport slave (
        input  in_valid, in_data, wr_en, wr_sel, wr_addr, wr_data, cfg_shift, out_ready,
        output in_ready, wr_err, out_valid, out_logit, busy
    );
endinterface

// File: rtl/fcn_tiled.sv
// fcn_tiled: two-layer fully-connected engine.
//   FC1: IN_N -> HID_M with bias, ReLU, runtime right shift, clamp to [0, 2^(DW-1)-1]
//   FC2: HID_M -> 1 signed logit with bias.
// Hidden neurons are processed in tiles of LANES parallel MACs.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   bus      fcn_tiled_if.slave (input stream, parameter writes, result handshake)
//   sat_flag sticky saturation indicator (only with FCN_TILED_SAT_EN)
// Build option: define FCN_TILED_SAT_EN to make every accumulator update
// saturate instead of wrapping, and to add the sat_flag output.
module fcn_tiled #(
    parameter int IN_N  = 132,
    parameter int HID_M = 10,
    parameter int LANES = 5,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    fcn_tiled_if.slave  bus
`ifdef FCN_TILED_SAT_EN
    ,
    output logic        sat_flag
`endif
);
    localparam int TILES  = (HID_M + LANES - 1) / LANES;
    localparam int W1_N   = HID_M * IN_N;
    localparam int BANK_D = TILES * IN_N;
    localparam int BA_W   = (BANK_D > 1) ? $clog2(BANK_D) : 1;
    localparam int IB_W   = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int CNT_W  = $clog2(((IN_N > HID_M) ? IN_N : HID_M) + 1);
    localparam int TILE_W = $clog2(TILES + 1);
    localparam int HID_AW = (HID_M > 1) ? $clog2(HID_M) : 1;
    localparam int QMAX   = 2**(DW-1) - 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_MAC, S_REQ, S_FC2, S_OUT} state_t;

    state_t r_state, w_state_next;
    logic   w_in_ready, w_out_valid, w_busy, w_beat;

    logic [CNT_W-1:0]        r_cnt;
    logic [TILE_W-1:0]       r_tile;
    logic [4:0]              r_shift;
    logic signed [ACC_W-1:0] r_fc2_acc, r_logit;
    logic                    r_wr_err;

    // Two's-complement add with one guard bit; saturates when the option is built in.
    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef FCN_TILED_SAT_EN
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        return s[ACC_W-1:0];
    endfunction

`ifdef FCN_TILED_SAT_EN
    function automatic logic acc_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        return s[ACC_W] != s[ACC_W-1];
    endfunction
`endif

    // ---------------- FSM ----------------
    assign w_beat = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) w_state_next = (IN_N == 1) ? S_CLR : S_LOAD;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_cnt == CNT_W'(IN_N-1)) w_state_next = S_CLR;
            end
            S_CLR: w_state_next = S_MAC;
            S_MAC: if (r_cnt == CNT_W'(IN_N-1)) w_state_next = S_REQ;
            S_REQ: w_state_next = (r_tile == TILE_W'(TILES-1)) ? S_FC2 : S_CLR;
            S_FC2: if (r_cnt == CNT_W'(HID_M-1)) w_state_next = S_OUT;
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_logit = r_logit;
    assign bus.wr_err    = r_wr_err;

    // ---------------- parameter write decode ----------------
    logic w_w1_ok, w_idx_ok, w_wr_ok;
    int   w_dec_n, w_dec_idx, w_dec_lane;
    logic [BA_W-1:0]   w_dec_ba;
    logic [HID_AW-1:0] w_dec_nid;

    assign w_dec_n    = int'(bus.wr_addr) / IN_N;
    assign w_dec_idx  = int'(bus.wr_addr) % IN_N;
    assign w_dec_lane = w_dec_n % LANES;
    // Lane bank holds its neurons tile after tile, IN_N weights each.
    assign w_dec_ba   = BA_W'((w_dec_n / LANES) * IN_N + w_dec_idx);
    assign w_dec_nid  = HID_AW'(bus.wr_addr);
    assign w_w1_ok    = 32'(bus.wr_addr) < 32'(W1_N);
    assign w_idx_ok   = 32'(bus.wr_addr) < 32'(HID_M);

    always_comb begin
        w_wr_ok = 1'b0;
        if (r_state == S_IDLE) begin
            case (bus.wr_sel)
                2'd0:    w_wr_ok = w_w1_ok;
                2'd1:    w_wr_ok = w_idx_ok;
                2'd2:    w_wr_ok = w_idx_ok;
                default: w_wr_ok = 1'b1;
            endcase
        end
    end

    logic signed [DW-1:0] r_w2 [HID_M];
    logic signed [DW-1:0] r_b1 [HID_M];
    logic signed [DW-1:0] r_b2;
    logic        [DW-1:0] r_hid [HID_M];

    always_ff @(posedge clk) begin
        if (bus.wr_en && w_wr_ok) begin
            if (bus.wr_sel == 2'd1) r_w2[w_dec_nid] <= bus.wr_data;
            if (bus.wr_sel == 2'd2) r_b1[w_dec_nid] <= bus.wr_data;
            if (bus.wr_sel == 2'd3) r_b2 <= bus.wr_data;
        end
    end

    // ---------------- input buffer (registered read) ----------------
    logic signed [DW-1:0] r_in_buf [IN_N];
    logic signed [DW-1:0] r_x;
    logic [CNT_W-1:0]     w_rd_k;
    logic [IB_W-1:0]      w_ib_waddr;
    logic [BA_W-1:0]      w_rd_ba;

    // Fetch one element ahead: S_CLR fetches k=0, S_MAC at k fetches k+1.
    assign w_rd_k     = (r_state == S_MAC && r_cnt != CNT_W'(IN_N-1)) ? r_cnt + 1'b1 : '0;
    assign w_rd_ba    = BA_W'(int'(r_tile) * IN_N + int'(w_rd_k));
    assign w_ib_waddr = (r_state == S_IDLE) ? '0 : IB_W'(r_cnt);

    always_ff @(posedge clk) begin
        if (w_beat) r_in_buf[w_ib_waddr] <= bus.in_data;
        r_x <= r_in_buf[IB_W'(w_rd_k)];
    end

    // ---------------- MAC lanes ----------------
    logic              w_lane_en  [LANES];
    logic [HID_AW-1:0] w_lane_nid [LANES];
    logic [DW-1:0]     w_lane_req [LANES];
`ifdef FCN_TILED_SAT_EN
    logic              w_lane_ovf [LANES];
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DW-1:0]    r_bank [BANK_D];
        logic signed [DW-1:0]    r_w_rd;
        logic signed [ACC_W-1:0] r_acc;
        logic signed [2*DW-1:0]  w_prod;
        logic signed [ACC_W-1:0] w_prod_ext;
        logic [ACC_W-1:0]        w_relu;
        int                      w_n;

        assign w_n            = int'(r_tile) * LANES + gi;
        assign w_lane_en[gi]  = w_n < HID_M;
        assign w_lane_nid[gi] = w_lane_en[gi] ? HID_AW'(w_n) : '0;

        always_ff @(posedge clk) begin
            if (bus.wr_en && w_wr_ok && bus.wr_sel == 2'd0 && w_dec_lane == gi)
                r_bank[w_dec_ba] <= bus.wr_data;
            r_w_rd <= r_bank[w_rd_ba];
        end

        assign w_prod     = r_w_rd * r_x;
        assign w_prod_ext = ACC_W'(w_prod);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_lane_en[gi]) begin
                if (r_state == S_CLR)      r_acc <= ACC_W'(r_b1[w_lane_nid[gi]]);
                else if (r_state == S_MAC) r_acc <= acc_add(r_acc, w_prod_ext);
            end
        end

`ifdef FCN_TILED_SAT_EN
        assign w_lane_ovf[gi] = w_lane_en[gi] && (r_state == S_MAC) && acc_ovf(r_acc, w_prod_ext);
`endif

        // ReLU, then shift, then clamp to the positive DW-bit range.
        assign w_relu         = r_acc[ACC_W-1] ? '0 : ($unsigned(r_acc) >> r_shift);
        assign w_lane_req[gi] = (w_relu > ACC_W'(QMAX)) ? DW'(QMAX) : w_relu[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REQ) begin
            for (int l = 0; l < LANES; l++)
                if (w_lane_en[l]) r_hid[w_lane_nid[l]] <= w_lane_req[l];
        end
    end

    // ---------------- FC2 ----------------
    logic [HID_AW-1:0]       w_m;
    logic signed [2*DW:0]    w_fc2_prod;
    logic signed [ACC_W-1:0] w_fc2_prod_ext, w_fc2_sum;

    assign w_m            = (r_state == S_FC2) ? HID_AW'(r_cnt) : '0;
    assign w_fc2_prod     = r_w2[w_m] * $signed({1'b0, r_hid[w_m]});
    assign w_fc2_prod_ext = ACC_W'(w_fc2_prod);
    assign w_fc2_sum      = acc_add(r_fc2_acc, w_fc2_prod_ext);

    // ---------------- counters and result ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tile    <= '0;
            r_shift   <= '0;
            r_fc2_acc <= '0;
            r_logit   <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_wr_err <= bus.wr_en && !w_wr_ok;
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= w_beat ? CNT_W'(1) : '0;
                    r_tile <= '0;
                end
                S_LOAD: if (w_beat) r_cnt <= r_cnt + 1'b1;
                S_CLR: begin
                    r_cnt <= '0;
                    if (r_tile == '0) r_shift <= bus.cfg_shift;
                end
                S_MAC: r_cnt <= (r_cnt == CNT_W'(IN_N-1)) ? '0 : r_cnt + 1'b1;
                S_REQ: begin
                    r_cnt <= '0;
                    if (r_tile == TILE_W'(TILES-1)) begin
                        r_tile    <= '0;
                        r_fc2_acc <= ACC_W'(r_b2);
                    end else begin
                        r_tile <= r_tile + 1'b1;
                    end
                end
                S_FC2: begin
                    r_fc2_acc <= w_fc2_sum;
                    if (r_cnt == CNT_W'(HID_M-1)) begin
                        r_cnt   <= '0;
                        r_logit <= w_fc2_sum;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

`ifdef FCN_TILED_SAT_EN
    logic r_sat, w_any_ovf;
    always_comb begin
        w_any_ovf = (r_state == S_FC2) && acc_ovf(r_fc2_acc, w_fc2_prod_ext);
        for (int l = 0; l < LANES; l++) w_any_ovf = w_any_ovf | w_lane_ovf[l];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_sat <= 1'b0;
        else if (w_beat && r_state == S_IDLE)     r_sat <= 1'b0;
        else if (w_any_ovf)                       r_sat <= 1'b1;
    end
    assign sat_flag = r_sat;
`endif
endmodule
